// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, bus payloads and operand-capture helpers for the ALU reservation station.
package alu_reservation_station_pkg;

  localparam int unsigned RS_SIZE        = 16;
  localparam int unsigned RS_SIZE_WIDTH  = 4;
  localparam int unsigned ROB_SIZE_WIDTH = 4;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned OP_WIDTH       = 5;
  localparam int unsigned OP_BRANCH_BIT  = 4;
  localparam int unsigned OP_ALT_BIT     = 3;

  typedef logic [ROB_SIZE_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic            valid;
    rob_tag_t        rob_id;
    logic [XLEN-1:0] value;
  } cdb_t;

  typedef struct packed {
    logic            busy;
    rob_tag_t        q;
    logic [XLEN-1:0] v;
  } operand_t;

  typedef struct packed {
    logic                busy;
    logic [OP_WIDTH-1:0] op;
    rob_tag_t            rob_id;
    operand_t            src1;
    operand_t            src2;
  } rs_entry_t;

  typedef struct packed {
    logic                en;
    rob_tag_t            rob_id;
    logic [OP_WIDTH-1:0] op;
    logic [XLEN-1:0]     v1;
    logic [XLEN-1:0]     v2;
  } alu_req_t;

  // Capture a pending operand from whichever CDB carries its tag; ALU bus has priority.
  function automatic operand_t snoop(operand_t o, cdb_t alu, cdb_t lsb);
    operand_t r;
    r = o;
    if (o.busy) begin
      if (alu.valid && (alu.rob_id == o.q)) begin
        r.busy = 1'b0;
        r.v    = alu.value;
      end else if (lsb.valid && (lsb.rob_id == o.q)) begin
        r.busy = 1'b0;
        r.v    = lsb.value;
      end
    end
    return r;
  endfunction

  function automatic logic entry_ready(rs_entry_t e);
    return e.busy & ~e.src1.busy & ~e.src2.busy;
  endfunction

  function automatic logic op_is_branch(logic [OP_WIDTH-1:0] op);
    return op[OP_BRANCH_BIT];
  endfunction

  function automatic logic op_is_alt(logic [OP_WIDTH-1:0] op);
    return op[OP_ALT_BIT];
  endfunction

endpackage

// File: rtl/alu_reservation_station_lowest_picker.sv
// Combinational priority picker: reports the lowest set bit of a request vector.
module alu_reservation_station_lowest_picker #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers micro-ops until operands arrive via CDB, issues one ready op per cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [OP_WIDTH-1:0]       issue_op,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [XLEN-1:0]           issue_v1,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_q1,
  input  logic                      issue_q1_busy,
  input  logic [XLEN-1:0]           issue_v2,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_q2,
  input  logic                      issue_q2_busy,
  output logic                      full,
  input  logic                      cdb_alu_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_alu_rob_id,
  input  logic [XLEN-1:0]           cdb_alu_value,
  input  logic                      cdb_lsb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_lsb_rob_id,
  input  logic [XLEN-1:0]           cdb_lsb_value,
  output logic                      alu_en,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  output logic [OP_WIDTH-1:0]       alu_op,
  output logic [XLEN-1:0]           alu_v1,
  output logic [XLEN-1:0]           alu_v2
);

  rs_entry_t entries_q [RS_SIZE];
  rs_entry_t entries_d [RS_SIZE];
  rs_entry_t new_entry;
  alu_req_t  alu_q;
  alu_req_t  alu_d;
  cdb_t      cdb_alu;
  cdb_t      cdb_lsb;

  logic [RS_SIZE-1:0]       busy_vec;
  logic [RS_SIZE-1:0]       free_vec;
  logic [RS_SIZE-1:0]       ready_vec;
  logic                     free_found;
  logic                     ready_found;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic [RS_SIZE_WIDTH-1:0] ready_idx;

  assign cdb_alu = {cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value};
  assign cdb_lsb = {cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value};

  // Occupancy and readiness are taken from registered state only.
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = entries_q[i].busy;
      ready_vec[i] = entry_ready(entries_q[i]);
    end
  end

  assign free_vec = ~busy_vec;
  assign full     = &busy_vec;

  alu_reservation_station_lowest_picker #(
    .N (RS_SIZE),
    .W (RS_SIZE_WIDTH)
  ) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  alu_reservation_station_lowest_picker #(
    .N (RS_SIZE),
    .W (RS_SIZE_WIDTH)
  ) u_ready_pick (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Incoming entry, with operands bypassed from a same-cycle broadcast.
  always_comb begin
    new_entry        = '0;
    new_entry.busy   = 1'b1;
    new_entry.op     = issue_op;
    new_entry.rob_id = issue_rob_id;
    new_entry.src1   = snoop({issue_q1_busy, issue_q1, issue_v1}, cdb_alu, cdb_lsb);
    new_entry.src2   = snoop({issue_q2_busy, issue_q2, issue_v2}, cdb_alu, cdb_lsb);
  end

  // Next state: flush, else snoop + dispatch + insert.
  always_comb begin
    entries_d = entries_q;
    alu_d     = alu_q;
    alu_d.en  = 1'b0;
    if (clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (entries_q[i].busy) begin
          entries_d[i].src1 = snoop(entries_q[i].src1, cdb_alu, cdb_lsb);
          entries_d[i].src2 = snoop(entries_q[i].src2, cdb_alu, cdb_lsb);
        end
      end
      if (ready_found) begin
        alu_d = '{en:     1'b1,
                  rob_id: entries_q[ready_idx].rob_id,
                  op:     entries_q[ready_idx].op,
                  v1:     entries_q[ready_idx].src1.v,
                  v2:     entries_q[ready_idx].src2.v};
        entries_d[ready_idx].busy = 1'b0;
      end
      // Slot chosen from pre-edge occupancy, so a slot freed by dispatch above is never reused here.
      if (issue_valid && free_found) begin
        entries_d[free_idx] = new_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      alu_q <= '0;
    end else if (rdy) begin
      entries_q <= entries_d;
      alu_q     <= alu_d;
    end
  end

  assign alu_en     = alu_q.en;
  assign alu_rob_id = alu_q.rob_id;
  assign alu_op     = alu_q.op;
  assign alu_v1     = alu_q.v1;
  assign alu_v2     = alu_q.v2;

  // Protocol checks: no insert into a full station, no tag on both buses at once.
  always_ff @(posedge clk) begin
    if (rst_n && rdy && !clear) begin
      a_issue_when_full: assert (!(issue_valid && full));
      a_dual_cdb_match: assert (!(cdb_alu_valid && cdb_lsb_valid &&
                                  (cdb_alu_rob_id == cdb_lsb_rob_id)));
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed and randomized checks of the ALU reservation station against a behavioural slot model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int unsigned N  = RS_SIZE;
  localparam int unsigned TW = ROB_SIZE_WIDTH;

  logic            clk;
  logic            rst_n;
  logic            rdy;
  logic            clear;
  logic            issue_valid;
  logic [4:0]      issue_op;
  logic [TW-1:0]   issue_rob_id;
  logic [31:0]     issue_v1;
  logic [TW-1:0]   issue_q1;
  logic            issue_q1_busy;
  logic [31:0]     issue_v2;
  logic [TW-1:0]   issue_q2;
  logic            issue_q2_busy;
  logic            full;
  logic            cdb_alu_valid;
  logic [TW-1:0]   cdb_alu_rob_id;
  logic [31:0]     cdb_alu_value;
  logic            cdb_lsb_valid;
  logic [TW-1:0]   cdb_lsb_rob_id;
  logic [31:0]     cdb_lsb_value;
  logic            alu_en;
  logic [TW-1:0]   alu_rob_id;
  logic [4:0]      alu_op;
  logic [31:0]     alu_v1;
  logic [31:0]     alu_v2;

  alu_reservation_station dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .clear          (clear),
    .issue_valid    (issue_valid),
    .issue_op       (issue_op),
    .issue_rob_id   (issue_rob_id),
    .issue_v1       (issue_v1),
    .issue_q1       (issue_q1),
    .issue_q1_busy  (issue_q1_busy),
    .issue_v2       (issue_v2),
    .issue_q2       (issue_q2),
    .issue_q2_busy  (issue_q2_busy),
    .full           (full),
    .cdb_alu_valid  (cdb_alu_valid),
    .cdb_alu_rob_id (cdb_alu_rob_id),
    .cdb_alu_value  (cdb_alu_value),
    .cdb_lsb_valid  (cdb_lsb_valid),
    .cdb_lsb_rob_id (cdb_lsb_rob_id),
    .cdb_lsb_value  (cdb_lsb_value),
    .alu_en         (alu_en),
    .alu_rob_id     (alu_rob_id),
    .alu_op         (alu_op),
    .alu_v1         (alu_v1),
    .alu_v2         (alu_v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          busy;
    logic [4:0]    op;
    logic [TW-1:0] rob;
    logic [31:0]   v1;
    logic [31:0]   v2;
    logic [TW-1:0] q1;
    logic [TW-1:0] q2;
    logic          p1;
    logic          p2;
  } ment_t;

  ment_t         m [N];
  logic          m_en;
  logic [TW-1:0] m_rob;
  logic [4:0]    m_op;
  logic [31:0]   m_v1;
  logic [31:0]   m_v2;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '{default: '0};
    m_en = 1'b0; m_rob = '0; m_op = '0; m_v1 = '0; m_v2 = '0;
  endtask

  // Value an operand holds after this edge, given the broadcasts currently on the buses.
  task automatic resolve(input logic p, input logic [TW-1:0] q, input logic [31:0] v,
                         output logic po, output logic [31:0] vo);
    po = p;
    vo = v;
    if (p && cdb_alu_valid && cdb_alu_rob_id == q) begin
      po = 1'b0; vo = cdb_alu_value;
    end else if (p && cdb_lsb_valid && cdb_lsb_rob_id == q) begin
      po = 1'b0; vo = cdb_lsb_value;
    end
  endtask

  task automatic model_edge();
    ment_t nx [N];
    int sel;
    int fr;
    logic po;
    logic [31:0] vo;
    if (!rdy) return;
    if (clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      m_en = 1'b0;
      return;
    end
    nx = m;
    sel = -1;
    fr = -1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && !m[i].p1 && !m[i].p2) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
      if (m[i].busy) begin
        resolve(m[i].p1, m[i].q1, m[i].v1, po, vo); nx[i].p1 = po; nx[i].v1 = vo;
        resolve(m[i].p2, m[i].q2, m[i].v2, po, vo); nx[i].p2 = po; nx[i].v2 = vo;
      end
    end
    m_en = (sel >= 0);
    if (sel >= 0) begin
      m_rob = m[sel].rob; m_op = m[sel].op; m_v1 = m[sel].v1; m_v2 = m[sel].v2;
      nx[sel].busy = 1'b0;
    end
    if (issue_valid && fr >= 0) begin
      nx[fr].busy = 1'b1; nx[fr].op = issue_op; nx[fr].rob = issue_rob_id;
      nx[fr].q1 = issue_q1; nx[fr].q2 = issue_q2;
      resolve(issue_q1_busy, issue_q1, issue_v1, po, vo); nx[fr].p1 = po; nx[fr].v1 = vo;
      resolve(issue_q2_busy, issue_q2, issue_v2, po, vo); nx[fr].p2 = po; nx[fr].v2 = vo;
    end
    m = nx;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".alu_en"}, 32'(alu_en), 32'(m_en));
    chk({tag, ".alu_rob_id"}, 32'(alu_rob_id), 32'(m_rob));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(m_op));
    chk({tag, ".alu_v1"}, alu_v1, m_v1);
    chk({tag, ".alu_v2"}, alu_v2, m_v2);
    chk({tag, ".full"}, 32'(full), 32'(m_full()));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; issue_valid = 1'b0;
    issue_op = '0; issue_rob_id = '0; issue_v1 = '0; issue_v2 = '0;
    issue_q1 = '0; issue_q2 = '0; issue_q1_busy = 1'b0; issue_q2_busy = 1'b0;
    cdb_alu_valid = 1'b0; cdb_alu_rob_id = '0; cdb_alu_value = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_rob_id = '0; cdb_lsb_value = '0;
  endtask

  task automatic set_issue(input logic [TW-1:0] rob, input logic [4:0] op,
                           input logic [31:0] v1, input logic b1, input logic [TW-1:0] q1,
                           input logic [31:0] v2, input logic b2, input logic [TW-1:0] q2);
    issue_valid = 1'b1; issue_rob_id = rob; issue_op = op;
    issue_v1 = v1; issue_q1_busy = b1; issue_q1 = q1;
    issue_v2 = v2; issue_q2_busy = b2; issue_q2 = q2;
  endtask

  initial begin
    total = 0;
    bad = 0;
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Both operands ready: dispatched on the edge after insertion.
    set_issue(4'd3, 5'b00000, 32'd7, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0);
    step("t1_ins");
    idle();
    step("t1_disp");
    chk("t1_en", 32'(alu_en), 32'd1);
    chk("t1_rob", 32'(alu_rob_id), 32'd3);
    chk("t1_v1", alu_v1, 32'd7);
    chk("t1_v2", alu_v2, 32'd5);
    step("t1_after");
    chk("t1_full", 32'(full), 32'd0);

    // Operand 1 woken by an ALU broadcast.
    set_issue(4'd4, 5'b00001, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0);
    step("t2_ins");
    idle();
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 4'd2; cdb_alu_value = 32'h10;
    step("t2_wake");
    chk("t2_wake_en", 32'(alu_en), 32'd0);
    idle();
    step("t2_disp");
    chk("t2_en", 32'(alu_en), 32'd1);
    chk("t2_v1", alu_v1, 32'h10);

    // Same-cycle LSB bypass at insertion.
    set_issue(4'd5, 5'b10010, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6);
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 4'd6; cdb_lsb_value = 32'hAB;
    step("t3_ins");
    idle();
    step("t3_disp");
    chk("t3_en", 32'(alu_en), 32'd1);
    chk("t3_rob", 32'(alu_rob_id), 32'd5);
    chk("t3_v2", alu_v2, 32'hAB);
    step("t3_after");

    // Fill every slot waiting on tag 9, then wake them all at once.
    for (int k = 0; k < N; k++) begin
      set_issue(4'(k), 5'(k), 32'd0, 1'b1, 4'd9, 32'(k + 100), 1'b0, 4'd0);
      step("t4_fill");
    end
    idle();
    chk("t4_full", 32'(full), 32'd1);
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 4'd9; cdb_alu_value = 32'h99;
    step("t4_wake");
    idle();
    for (int k = 0; k < N; k++) begin
      step("t4_drain");
      chk("t4_order", 32'(alu_rob_id), 32'(k));
      chk("t4_v1", alu_v1, 32'h99);
      if (k == 0) chk("t4_full_after_first", 32'(full), 32'd0);
    end
    step("t4_empty");
    chk("t4_done_en", 32'(alu_en), 32'd0);

    // Flush with ready entries and a competing insert.
    for (int k = 1; k <= 3; k++) begin
      set_issue(4'(k), 5'd1, 32'd0, 1'b1, 4'd12, 32'd2, 1'b0, 4'd0);
      step("t5_ins");
    end
    idle();
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 4'd12; cdb_lsb_value = 32'h55;
    step("t5_wake");
    idle();
    clear = 1'b1;
    set_issue(4'd7, 5'd2, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
    step("t5_clear");
    idle();
    for (int k = 0; k < 3; k++) begin
      step("t5_post");
      chk("t5_no_en", 32'(alu_en), 32'd0);
    end

    // Pause with ready entries, live CDB and an insert request.
    for (int k = 1; k <= 3; k++) begin
      set_issue(4'(k + 10), 5'(k), 32'd0, 1'b1, 4'd13, 32'(k), 1'b0, 4'd0);
      step("t6_ins");
    end
    idle();
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 4'd13; cdb_alu_value = 32'h13;
    step("t6_wake");
    idle();
    step("t6_disp");
    chk("t6_first", 32'(alu_rob_id), 32'd11);
    rdy = 1'b0;
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 4'd14; cdb_lsb_value = 32'hEE;
    set_issue(4'd15, 5'd3, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      step("t6_hold");
      chk("t6_hold_en", 32'(alu_en), 32'd1);
      chk("t6_hold_rob", 32'(alu_rob_id), 32'd11);
    end
    idle();
    step("t6_resume");
    chk("t6_resume_rob", 32'(alu_rob_id), 32'd12);
    step("t6_last");

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 39) == 0);
      if (!m_full() && $urandom_range(0, 1) == 1)
        set_issue(4'($urandom), 5'($urandom), $urandom, 1'($urandom), 4'($urandom_range(0, 7)),
                  $urandom, 1'($urandom), 4'($urandom_range(0, 7)));
      cdb_alu_valid = 1'($urandom);
      cdb_alu_rob_id = 4'($urandom_range(0, 7));
      cdb_alu_value = $urandom;
      cdb_lsb_valid = 1'($urandom);
      cdb_lsb_rob_id = 4'($urandom_range(0, 7));
      cdb_lsb_value = $urandom;
      if (cdb_lsb_rob_id == cdb_alu_rob_id) cdb_lsb_rob_id = cdb_alu_rob_id ^ 4'd1;
      step("rand");
    end

    // Async reset mid-stream with entries in flight.
    idle();
    for (int k = 0; k < 4; k++) begin
      set_issue(4'(k), 5'd0, 32'(k), 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
      step("t7_ins");
    end
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t7_rst_en", 32'(alu_en), 32'd0);
    chk("t7_rst_full", 32'(full), 32'd0);
    chk("t7_rst_v1", alu_v1, 32'd0);
    @(posedge clk);
    #1;
    check_all("t7_in_rst");
    rst_n = 1'b1;
    step("t7_post");
    chk("t7_post_en", 32'(alu_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
